// File: rtl/mips_cpu_lsu_avalon.sv
// Load/store unit bridging the MIPS execute stage and an Avalon-MM data bus.
// Aligns store data into byte lanes, extracts and extends load data, stalls
// the pipeline while a bus access is in flight and flags bad requests.
module mips_cpu_lsu_avalon #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    lat_size;
  logic [1:0]    lat_off;
  logic          lat_unsigned;

  logic          req_illegal;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   load_ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // Classify the incoming request and build its lane enables and store data
  always_comb begin
    req_illegal = 1'b0;
    be_next     = 4'b0000;
    wdata_next  = req_wdata;
    case (req_size)
      2'b00: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_illegal = req_addr[0];
        be_next     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_illegal = (req_addr[1:0] != 2'b00);
        be_next     = 4'b1111;
        wdata_next  = req_wdata;
      end
      default: begin
        req_illegal = 1'b1;
      end
    endcase
  end

  // Pick the addressed lane out of the read data and extend it to 32 bits
  always_comb begin
    byte_sel = avm_readdata[8*lat_off +: 8];
    half_sel = lat_off[1] ? avm_readdata[31:16] : avm_readdata[15:0];
    case (lat_size)
      2'b00:   load_ext = lat_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = lat_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = avm_readdata;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == BUS);

  // Access sequencer: accept in IDLE, hold the bus until the slave is ready or we give up, then respond once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      lat_size       <= 2'b00;
      lat_off        <= 2'b00;
      lat_unsigned   <= 1'b0;
      avm_address    <= 32'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'b0;
      avm_writedata  <= 32'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'b0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
              state      <= RESP;
            end else begin
              avm_address    <= {req_addr[31:2], 2'b00};
              avm_read       <= ~req_write;
              avm_write      <= req_write;
              avm_byteenable <= be_next;
              avm_writedata  <= wdata_next;
              lat_size       <= req_size;
              lat_off        <= req_addr[1:0];
              lat_unsigned   <= req_unsigned;
              wait_cnt       <= '0;
              state          <= BUS;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            if (avm_read) begin
              resp_rdata <= load_ext;
            end
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if ((MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT - 1))) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'b0;
            wait_cnt   <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu_avalon.sv
// Self-checking bench for mips_cpu_lsu_avalon: directed corner cases followed
// by random loads/stores, all checked against a lane-level reference model.
module tb_mips_cpu_lsu_avalon;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int          num_checks;
  int          num_fails;
  logic [31:0] model_rdata;
  logic        rdata_known;
  logic [31:0] obs_rdata;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;

  mips_cpu_lsu_avalon #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .stall           (stall),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = v;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  function automatic logic isIllegal(input logic [1:0] sz, input logic [31:0] addr);
    int nbytes;
    if (sz == 2'b11) return 1'b1;
    nbytes = 1 << sz;
    return (addr % nbytes) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be;
    int nbytes;
    int off;
    nbytes = 1 << sz;
    off    = int'(addr % 4);
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + nbytes);
    return be;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] res;
    int nbytes;
    nbytes = 1 << sz;
    res = 32'b0;
    for (int k = 0; k < 4; k++) res = res | (((wd >> (8 * (k % nbytes))) & 32'hFF) << (8 * k));
    return res;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic uns,
                                            input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    longint span;
    int bits;
    bits = 8 * (1 << sz);
    span = longint'(1) << bits;
    v = longint'((rd >> (8 * (addr % 4)))) % span;
    if (!uns && bits < 32 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One complete CPU access: issue, serve the bus with the given wait count, check the response
  task automatic doOp(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                      input int waits);
    logic illegal;
    logic timeout;
    logic exp_err;
    int bus_cycles;
    illegal = isIllegal(sz, addr);
    timeout = !illegal && (waits >= MAX_WAIT);
    applyStimulus(1'b1, wr, sz, uns, addr, wd);
    avm_waitrequest = 1'b0;
    avm_readdata    = $urandom;
    #1;
    checkOutput({tag, "_ready0"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_stall0"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    if (!illegal) begin
      bus_cycles = timeout ? MAX_WAIT : waits + 1;
      for (int c = 0; c < bus_cycles; c++) begin
        applyStimulus(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        avm_waitrequest = (c < waits);
        avm_readdata    = (c < waits) ? $urandom : rd;
        #1;
        if (c == 0) begin
          obs_be    = avm_byteenable;
          obs_wdata = avm_writedata;
          obs_addr  = avm_address;
        end
        checkOutput({tag, "_read"}, 32'(avm_read), 32'(!wr));
        checkOutput({tag, "_write"}, 32'(avm_write), 32'(wr));
        checkOutput({tag, "_addr"}, avm_address, addr & 32'hFFFF_FFFC);
        checkOutput({tag, "_be"}, 32'(avm_byteenable), 32'(modelBe(sz, addr)));
        if (wr) checkOutput({tag, "_wdata"}, avm_writedata, modelWdata(sz, wd));
        checkOutput({tag, "_stall_bus"}, 32'(stall), 32'd1);
        checkOutput({tag, "_ready_bus"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_rvalid_bus"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
      end
    end
    exp_err = illegal || timeout;
    if (exp_err) begin
      model_rdata = 32'b0;
      rdata_known = 1'b1;
    end else if (!wr) begin
      model_rdata = modelLoad(sz, uns, addr, rd);
      rdata_known = 1'b1;
    end else begin
      rdata_known = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'b0, 32'b0);
    avm_waitrequest = 1'b0;
    #1;
    obs_rdata = resp_rdata;
    checkOutput({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    if (rdata_known) checkOutput({tag, "_rdata"}, resp_rdata, model_rdata);
    checkOutput({tag, "_read_resp"}, 32'(avm_read), 32'd0);
    checkOutput({tag, "_write_resp"}, 32'(avm_write), 32'd0);
    checkOutput({tag, "_stall_resp"}, 32'(stall), 32'd0);
    checkOutput({tag, "_ready_resp"}, 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    checkOutput({tag, "_rvalid_end"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_err_end"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_ready_end"}, 32'(req_ready), 32'd1);
    if (rdata_known) checkOutput({tag, "_rdata_hold"}, resp_rdata, model_rdata);
    @(posedge clk); #1;
  endtask

  // Main sequence: reset, directed scenarios, reset mid-access, random traffic
  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          r;
    int          waits;
    num_checks  = 0;
    num_fails   = 0;
    model_rdata = 32'b0;
    rdata_known = 1'b1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'b0, 32'b0);
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'b0;
    #3;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_read", 32'(avm_read), 32'd0);
    checkOutput("rst_write", 32'(avm_write), 32'd0);
    checkOutput("rst_addr", avm_address, 32'd0);
    checkOutput("rst_be", 32'(avm_byteenable), 32'd0);
    checkOutput("rst_wdata", avm_writedata, 32'd0);
    checkOutput("rst_rvalid", 32'(resp_valid), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    doOp("t1_lb", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    checkOutput("t1_be_const", 32'(obs_be), 32'b1000);
    checkOutput("t1_addr_const", obs_addr, 32'h0000_1000);
    checkOutput("t1_rdata_const", obs_rdata, 32'hFFFF_FF80);

    doOp("t2_lhu", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_0000, 3);
    checkOutput("t2_rdata_const", obs_rdata, 32'h0000_8001);

    doOp("t3_sb", 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 0);
    checkOutput("t3_be_const", 32'(obs_be), 32'b0010);
    checkOutput("t3_wdata_const", obs_wdata, 32'hABAB_ABAB);

    doOp("t4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h1234_5678, 0);
    checkOutput("t4_rdata_const", obs_rdata, 32'h0);

    doOp("t5_timeout", 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 50);
    doOp("t5_sw", 1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 1);
    checkOutput("t5_wdata_const", obs_wdata, 32'hCAFE_F00D);

    // Reset in the middle of a stalled read
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_read_before", 32'(avm_read), 32'd1);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_read_async", 32'(avm_read), 32'd0);
    checkOutput("t6_ready_async", 32'(req_ready), 32'd1);
    checkOutput("t6_rvalid_async", 32'(resp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    model_rdata = 32'b0;
    rdata_known = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("t6_rvalid_after", 32'(resp_valid), 32'd0);
      checkOutput("t6_ready_after", 32'(req_ready), 32'd1);
    end
    doOp("t6_lh", 1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0, 32'hF00F_0000, 2);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if (sz != 2'b11 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << sz) - 32'd1);
      r = int'($urandom_range(0, 9));
      waits = (r < 8) ? (r % 4) : MAX_WAIT + int'($urandom_range(0, 3));
      doOp("rnd", 1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom, waits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
